fp21_normalize_pack: RTL and testbench

FP21_NORMALIZE_PACK -- requirements
Module: fp21_normalize_pack

---
 rtl/fp21_normalize_pack_if.sv | 28 ++
 rtl/fp21_normalize_pack.sv | 155 +++++++++++++++
 tb/tb_fp21_normalize_pack.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/fp21_normalize_pack_if.sv
// Handshake bundle for the FP21 normalize/pack pipeline.
// Upstream drives in_*, downstream drives out_ready.
interface fp21_normalize_pack_if #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 12
);
    logic                       in_valid;
    logic                       in_ready;
    logic                       in_sign;
    logic [EXP_W+1:0]           in_exp;
    logic [2*FRAC_W+1:0]        in_mant;
    logic                       in_zero;
    logic                       out_valid;
    logic                       out_ready;
    logic [EXP_W+FRAC_W:0]      out_fp;
    logic                       out_ovf;
    logic                       out_unf;

    modport master (
        output in_valid, in_sign, in_exp, in_mant, in_zero, out_ready,
        input  in_ready, out_valid, out_fp, out_ovf, out_unf
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_mant, in_zero, out_ready,
        output in_ready, out_valid, out_fp, out_ovf, out_unf
    );
endinterface

// File: rtl/fp21_normalize_pack.sv
// FP21 normalize/round/pack: S1 leading-one detect, S2 shift/round, S3 pack.
// Define FP21_ROUND_EN for round-to-nearest-even; otherwise fraction truncates.
module fp21_normalize_pack #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 12
) (
    input logic                  clk,
    input logic                  rst,
    fp21_normalize_pack_if.slave bus
);
    localparam int MW   = 2*FRAC_W + 2;
    localparam int XW   = EXP_W + 2;
    localparam int EW   = EXP_W + 4;
    localparam int PW   = $clog2(MW);
    localparam int FW   = 1 + EXP_W + FRAC_W;
    localparam int BIAS = (1 << (EXP_W-1)) - 1;
    localparam int EMAX = (1 << EXP_W) - 1;

    localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
    localparam logic signed [EW-1:0] EMAX_S = EW'(EMAX);

`ifdef FP21_ROUND_EN
    localparam logic ROUND = 1'b1;
`else
    localparam logic ROUND = 1'b0;
`endif

    typedef struct packed {
        logic          vld;
        logic          sign;
        logic          zero;
        logic [XW-1:0] exp;
        logic [MW-1:0] mant;
        logic [PW-1:0] pos;
    } s1_t;

    typedef struct packed {
        logic                 vld;
        logic                 sign;
        logic                 zero;
        logic signed [EW-1:0] e;
        logic [FRAC_W-1:0]    frac;
    } s2_t;

    typedef struct packed {
        logic          vld;
        logic [FW-1:0] fp;
        logic          ovf;
        logic          unf;
    } s3_t;

    s1_t s1_d, s1_q;
    s2_t s2_d, s2_q;
    s3_t s3_d, s3_q;

    logic                 adv;
    logic [PW-1:0]        lod_pos;
    logic [PW-1:0]        sh;
    logic [MW-2:0]        nrm;
    logic [FRAC_W-1:0]    frac;
    logic                 guard;
    logic                 sticky;
    logic                 rnd;
    logic                 cy;
    logic [FRAC_W-1:0]    fr;
    logic signed [EW-1:0] e;
    logic signed [EW-1:0] be;
    logic                 ovf;
    logic                 unf;
    logic [FW-1:0]        fp;

    // Whole pipeline advances together unless the output is blocked
    assign adv          = bus.out_ready | ~s3_q.vld;
    assign bus.in_ready = adv;
    assign bus.out_valid = s3_q.vld;
    assign bus.out_fp    = s3_q.fp;
    assign bus.out_ovf   = s3_q.ovf;
    assign bus.out_unf   = s3_q.unf;

    // Leading-one position of the incoming magnitude (highest set bit wins)
    always_comb begin
        lod_pos = '0;
        for (int i = 0; i < MW; i++) begin
            if (bus.in_mant[i]) lod_pos = PW'(i);
        end
    end

    // S1 next state: capture operand and leading-one position
    always_comb begin
        s1_d = s1_q;
        if (adv) begin
            s1_d.vld  = bus.in_valid;
            s1_d.sign = bus.in_sign;
            s1_d.zero = bus.in_zero | ~|bus.in_mant;
            s1_d.exp  = bus.in_exp;
            s1_d.mant = bus.in_mant;
            s1_d.pos  = lod_pos;
        end
    end

    // S2 next state: left-justify, extract fraction, round, adjust exponent
    always_comb begin
        sh     = PW'(MW-1) - s1_q.pos;
        nrm    = (MW-1)'(s1_q.mant << sh);
        frac   = nrm[MW-2 -: FRAC_W];
        guard  = nrm[MW-2-FRAC_W];
        sticky = |nrm[MW-3-FRAC_W:0];
        rnd    = ROUND & guard & (sticky | frac[0]);
        {cy, fr} = {1'b0, frac} + (FRAC_W+1)'(rnd);
        e = {{(EW-XW){s1_q.exp[XW-1]}}, s1_q.exp}
            + EW'(s1_q.pos) - EW'(2*FRAC_W);
        s2_d = s2_q;
        if (adv) begin
            s2_d.vld  = s1_q.vld;
            s2_d.sign = s1_q.sign;
            s2_d.zero = s1_q.zero;
            s2_d.frac = fr;
            s2_d.e    = cy ? e + EW'(1) : e;
        end
    end

    // S3 next state: bias, range-check and pack the output word
    always_comb begin
        be  = s2_q.e + BIAS_S;
        ovf = ~s2_q.zero & (be >= EMAX_S);
        unf = ~s2_q.zero & (be[EW-1] | (be == '0));
        if (s2_q.zero || unf) begin
            fp = {s2_q.sign, {(FW-1){1'b0}}};
        end else if (ovf) begin
            fp = {s2_q.sign, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end else begin
            fp = {s2_q.sign, be[EXP_W-1:0], s2_q.frac};
        end
        s3_d = s3_q;
        if (adv) begin
            s3_d.vld = s2_q.vld;
            s3_d.fp  = fp;
            s3_d.ovf = s2_q.vld & ovf;
            s3_d.unf = s2_q.vld & unf;
        end
    end

    // Stage registers; reset drops everything in flight
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end
endmodule

// File: tb/tb_fp21_normalize_pack.sv
// Directed bench for fp21_normalize_pack: vectors, latency, stall, reset.
// Expected values are hand-computed; FP21_ROUND_EN selects rounding set.
module tb_fp21_normalize_pack;
    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   failures = 0;

`ifdef FP21_ROUND_EN
    localparam bit RND = 1'b1;
`else
    localparam bit RND = 1'b0;
`endif

    localparam logic [31:0] E_ODD   = RND ? 32'h07F002 : 32'h07F001;
    localparam logic [31:0] E_CARRY = RND ? 32'h080000 : 32'h07FFFF;
    localparam logic [31:0] E_TOP   = RND ? 32'h0FF000 : 32'h0FEFFF;
    localparam logic [31:0] E_TOPO  = RND ? 32'd1 : 32'd0;

    fp21_normalize_pack_if bus ();

    fp21_normalize_pack dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic s, input logic [9:0] x,
                         input logic [25:0] m, input logic z);
        bus.in_sign = s;
        bus.in_exp  = x;
        bus.in_mant = m;
        bus.in_zero = z;
    endtask

    task automatic push(input logic s, input logic [9:0] x,
                        input logic [25:0] m, input logic z);
        int n;
        n = 0;
        drive(s, x, m, z);
        bus.in_valid = 1'b1;
        while (!bus.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("push_rdy", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic run(input string tag, input logic s, input logic [9:0] x,
                       input logic [25:0] m, input logic z,
                       input logic [31:0] efp, input logic [31:0] eovf,
                       input logic [31:0] eunf);
        int lat;
        push(s, x, m, z);
        lat = 1;
        while (!bus.out_valid && lat < 8) begin
            @(negedge clk);
            lat++;
        end
        chk({tag, "_lat"}, 32'(lat), 32'd3);
        chk({tag, "_fp"}, 32'(bus.out_fp), efp);
        chk({tag, "_ovf"}, 32'(bus.out_ovf), eovf);
        chk({tag, "_unf"}, 32'(bus.out_unf), eunf);
        @(negedge clk);
    endtask

    initial begin
        logic [20:0] got[$];
        int extra;

        rst = 1'b1;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        drive(1'b0, 10'd0, 26'd0, 1'b0);
        repeat (3) @(negedge clk);
        chk("rst_vld", 32'(bus.out_valid), 32'd0);
        chk("rst_fp", 32'(bus.out_fp), 32'd0);
        chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
        chk("rst_unf", 32'(bus.out_unf), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", 32'(bus.in_ready), 32'd1);

        run("one",   0, 10'd0,      26'h1000000, 0, 32'h07F000, 0, 0);
        run("p225",  0, 10'd0,      26'h2400000, 0, 32'h080200, 0, 0);
        run("tie",   0, 10'd0,      26'h1000800, 0, 32'h07F000, 0, 0);
        run("odd",   0, 10'd0,      26'h1001800, 0, E_ODD,      0, 0);
        run("carry", 0, 10'd0,      26'h1FFF800, 0, E_CARRY,    0, 0);
        run("ovf",   1, 10'd128,    26'h1000000, 0, 32'h1FF000, 1, 0);
        run("unf",   0, 10'(-127),  26'h1000000, 0, 32'h000000, 0, 1);
        run("minn",  0, 10'(-126),  26'h1000000, 0, 32'h001000, 0, 0);
        run("maxn",  0, 10'd127,    26'h1000000, 0, 32'h0FE000, 0, 0);
        run("top",   0, 10'd127,    26'h1FFF800, 0, E_TOP,      E_TOPO, 0);
        run("lsb",   0, 10'd0,      26'h0000001, 0, 32'h067000, 0, 0);
        run("zflag", 1, 10'd5,      26'h1234567, 1, 32'h100000, 0, 0);
        run("zmant", 0, 10'd100,    26'h0000000, 0, 32'h000000, 0, 0);

        bus.out_ready = 1'b0;
        push(0, 10'd0, 26'h1000000, 0);
        push(0, 10'd0, 26'h2400000, 0);
        push(0, 10'd1, 26'h1000000, 0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_rdy", 32'(bus.in_ready), 32'd0);
            chk("stall_vld", 32'(bus.out_valid), 32'd1);
            chk("stall_fp", 32'(bus.out_fp), 32'h07F000);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12 && got.size() < 3; i++) begin
            if (bus.out_valid) got.push_back(bus.out_fp);
            @(negedge clk);
        end
        extra = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.out_valid) extra++;
            @(negedge clk);
        end
        chk("order_n", 32'(got.size()), 32'd3);
        chk("order_0", 32'(got[0]), 32'h07F000);
        chk("order_1", 32'(got[1]), 32'h080200);
        chk("order_2", 32'(got[2]), 32'h080000);
        chk("order_dup", 32'(extra), 32'd0);

        push(0, 10'd0, 26'h1000000, 0);
        push(0, 10'd0, 26'h2400000, 0);
        push(0, 10'd1, 26'h1000000, 0);
        chk("flt_vld", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        drive(0, 10'd2, 26'h1000000, 0);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("flt_rvld", 32'(bus.out_valid), 32'd0);
        chk("flt_rfp", 32'(bus.out_fp), 32'd0);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("flt_rdy", 32'(bus.in_ready), 32'd1);
        extra = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (bus.out_valid) extra++;
        end
        chk("flt_stale", 32'(extra), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
